gate_controller: RTL and testbench

GATE_CONTROLLER -- requirements
Module: gate_controller

---
 rtl/gate_controller.sv | 167 ++++++++++++++++
 tb/tb_gate_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gate_controller.sv
// Parking gate barrier controller.
// Sequences a barrier through IDLE -> RAISING -> OPEN -> LOWERING -> IDLE,
// or IDLE -> DENY -> IDLE when no space is free. It admits one car per
// open cycle and re-raises if a car is still under the barrier while it lowers.
// All outputs are registered. Reset is synchronous and active-low.
// Optional feature macro: GATE_TIMEOUT_EN. When it is defined, an open barrier
// that sees no car within OPEN_TIMEOUT cycles closes and pulses timeout.
module gate_controller #(
    parameter int unsigned MOVE_CYCLES  = 50000000,
    parameter int unsigned OPEN_TIMEOUT = 500000000,
    parameter int unsigned DENY_CYCLES  = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic request,
    input  logic space_avail,
    input  logic car_passed,
    output logic gate_open,
    output logic gate_moving,
    output logic entry_pulse,
    output logic denied,
    output logic timeout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RAISING  = 3'd1;
    localparam logic [2:0] S_OPEN     = 3'd2;
    localparam logic [2:0] S_LOWERING = 3'd3;
    localparam logic [2:0] S_DENY     = 3'd4;

    // Terminal count values. The counter starts at 0 when a state is entered,
    // so a state lasting N cycles exits when the count reaches N-1.
    localparam logic [31:0] MOVE_LAST = 32'(MOVE_CYCLES - 1);
    localparam logic [31:0] DENY_LAST = 32'(DENY_CYCLES - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;
`ifdef GATE_TIMEOUT_EN
    localparam logic [31:0] OPEN_LAST = 32'(OPEN_TIMEOUT - 1);
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, car_q;
    logic        gate_open_q, gate_open_d;
    logic        gate_moving_q, gate_moving_d;
    logic        entry_pulse_q, entry_pulse_d;
    logic        denied_q, denied_d;
`ifdef GATE_TIMEOUT_EN
    logic        timeout_q, timeout_d;
`endif

    logic req_rise;
    logic car_rise;

    // A rising edge is the current input high while last cycle's sample was low.
    assign req_rise = request & ~req_q;
    assign car_rise = car_passed & ~car_q;

    // Next-state, counter and next-output logic.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        // Saturate rather than wrap so a long OPEN wait can never alias a terminal count.
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
        entry_pulse_d = 1'b0;
`ifdef GATE_TIMEOUT_EN
        timeout_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_rise) begin
                    state_d = space_avail ? S_RAISING : S_DENY;
                end
            end
            S_RAISING: begin
                // space_avail is deliberately ignored here: a raise in progress completes.
                if (cnt_q == MOVE_LAST) begin
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                if (car_rise) begin
                    state_d       = S_LOWERING;
                    entry_pulse_d = 1'b1;
                end
`ifdef GATE_TIMEOUT_EN
                else if (cnt_q == OPEN_LAST) begin
                    state_d   = S_LOWERING;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_LOWERING: begin
                // A car still under the barrier (level, not edge) forces a fresh raise.
                if (car_passed) begin
                    state_d = S_RAISING;
                end else if (cnt_q == MOVE_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_DENY: begin
                if (cnt_q == DENY_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state entry (including LOWERING -> RAISING) restarts the count.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state so the registered copies
        // line up with the state register.
        gate_open_d   = (state_d == S_OPEN);
        gate_moving_d = (state_d == S_RAISING) || (state_d == S_LOWERING);
        denied_d      = (state_d == S_DENY);
    end

    // State, counter, edge-detect and output registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            car_q         <= 1'b0;
            gate_open_q   <= 1'b0;
            gate_moving_q <= 1'b0;
            entry_pulse_q <= 1'b0;
            denied_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= request;
            car_q         <= car_passed;
            gate_open_q   <= gate_open_d;
            gate_moving_q <= gate_moving_d;
            entry_pulse_q <= entry_pulse_d;
            denied_q      <= denied_d;
        end
    end

`ifdef GATE_TIMEOUT_EN
    // Timeout pulse register, present only when the open window is bounded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gate_open   = gate_open_q;
    assign gate_moving = gate_moving_q;
    assign entry_pulse = entry_pulse_q;
    assign denied      = denied_q;

endmodule

// File: tb/tb_gate_controller.sv
// Directed testbench for gate_controller (MOVE_CYCLES=4, OPEN_TIMEOUT=20,
// DENY_CYCLES=3). Each step drives inputs on the falling edge, queues the
// output vector expected after the next rising edge, and compares it on the
// following falling edge.
module tb_gate_controller;

    localparam int unsigned MOVE = 4;
    localparam int unsigned TOUT = 20;
    localparam int unsigned DENY = 3;

    // Output vector order: {gate_open, gate_moving, entry_pulse, denied, timeout}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_OPEN  = 5'b10000;
    localparam logic [4:0] O_MOVE  = 5'b01000;
    localparam logic [4:0] O_ENTRY = 5'b01100;
    localparam logic [4:0] O_DENY  = 5'b00010;
    localparam logic [4:0] O_TOUT  = 5'b01001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic request = 1'b0;
    logic space_avail = 1'b0;
    logic car_passed = 1'b0;
    logic gate_open, gate_moving, entry_pulse, denied, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_entry  = 0;
    int entry_base;
    logic [4:0] exp_q[$];

    gate_controller #(
        .MOVE_CYCLES (MOVE),
        .OPEN_TIMEOUT(TOUT),
        .DENY_CYCLES (DENY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .space_avail(space_avail),
        .car_passed (car_passed),
        .gate_open  (gate_open),
        .gate_moving(gate_moving),
        .entry_pulse(entry_pulse),
        .denied     (denied),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, expect 'exp' after the next rising edge.
    task automatic step(input logic rst, input logic req, input logic sa,
                        input logic car, input logic [4:0] exp, input string tag);
        logic [4:0] e;
        logic [4:0] o;
        reset       = rst;
        request     = req;
        space_avail = sa;
        car_passed  = car;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        o = {gate_open, gate_moving, entry_pulse, denied, timeout};
        if (o[2] === 1'b1) n_entry++;
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic check_entries(input int want, input string tag);
        n_checks++;
        assert (n_entry === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d entry pulses expected %0d", tag, n_entry, want);
        end
    endtask

    // Request edge with space, four travel cycles, then fully open.
    task automatic raise_to_open(input string tag);
        step(1, 1, 1, 0, O_MOVE, tag);
        for (int i = 1; i < MOVE; i++) step(1, 0, 1, 0, O_MOVE, tag);
        step(1, 0, 1, 0, O_OPEN, tag);
    endtask

    // One-cycle car pulse while open: entry pulse, four lowering cycles, idle.
    task automatic car_and_lower(input string tag);
        step(1, 0, 1, 1, O_ENTRY, tag);
        for (int i = 1; i < MOVE; i++) step(1, 0, 1, 0, O_MOVE, tag);
        step(1, 0, 1, 0, O_IDLE, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        // Reset state
        step(0, 0, 1, 0, O_IDLE, "reset_hold");
        step(0, 0, 1, 0, O_IDLE, "reset_hold2");
        step(1, 0, 1, 0, O_IDLE, "idle_after_reset");

        // Normal admit cycle
        entry_base = n_entry;
        raise_to_open("admit_raise");
        step(1, 0, 1, 0, O_OPEN, "admit_open_wait");
        car_and_lower("admit_lower");
        step(1, 0, 1, 0, O_IDLE, "admit_idle");
        check_entries(entry_base + 1, "admit_entry_count");

        // Deny when no space
        step(1, 1, 0, 0, O_DENY, "deny");
        for (int i = 1; i < DENY; i++) step(1, 0, 0, 0, O_DENY, "deny");
        step(1, 0, 0, 0, O_IDLE, "deny_end");
        step(1, 0, 0, 0, O_IDLE, "deny_idle");
        check_entries(entry_base + 1, "deny_no_entry");

        // Car still under barrier while lowering forces a re-raise
        entry_base = n_entry;
        raise_to_open("bounce_raise");
        step(1, 0, 1, 1, O_ENTRY, "bounce_entry");
        step(1, 0, 1, 1, O_MOVE, "bounce_reraise");
        step(1, 0, 1, 1, O_MOVE, "bounce_reraise");
        step(1, 0, 1, 0, O_MOVE, "bounce_reraise");
        step(1, 0, 1, 0, O_MOVE, "bounce_reraise");
        step(1, 0, 1, 0, O_OPEN, "bounce_open");
        check_entries(entry_base + 1, "bounce_entry_count");
        // Reset while open clears everything on that edge
        step(0, 0, 1, 0, O_IDLE, "reset_in_open");
        step(1, 0, 1, 0, O_IDLE, "reset_in_open_release");

        // Request edges during RAISING/OPEN are ignored; space loss does not abort
        entry_base = n_entry;
        step(1, 1, 1, 0, O_MOVE, "ignore_raise");
        step(1, 0, 0, 0, O_MOVE, "ignore_raise");
        step(1, 1, 0, 0, O_MOVE, "ignore_raise_edge1");
        step(1, 0, 0, 0, O_MOVE, "ignore_raise");
        step(1, 1, 0, 0, O_OPEN, "ignore_open_edge2");
        step(1, 0, 0, 0, O_OPEN, "ignore_open");
        step(1, 1, 0, 0, O_OPEN, "ignore_open_edge3");
        step(1, 0, 0, 0, O_OPEN, "ignore_open");
        car_and_lower("ignore_lower");
        step(1, 0, 1, 0, O_IDLE, "ignore_idle");
        check_entries(entry_base + 1, "ignore_entry_count");

        // Open window with no car
        entry_base = n_entry;
        raise_to_open("window_raise");
`ifdef GATE_TIMEOUT_EN
        for (int i = 1; i < TOUT; i++) step(1, 0, 1, 0, O_OPEN, "window_open");
        step(1, 0, 1, 0, O_TOUT, "window_timeout");
        for (int i = 1; i < MOVE; i++) step(1, 0, 1, 0, O_MOVE, "window_lower");
        step(1, 0, 1, 0, O_IDLE, "window_idle");
        check_entries(entry_base, "window_no_entry");
`else
        for (int i = 0; i < 100; i++) step(1, 0, 1, 0, O_OPEN, "window_stay_open");
        check_entries(entry_base, "window_no_entry");
        step(0, 0, 1, 0, O_IDLE, "window_reset");
        step(1, 0, 1, 0, O_IDLE, "window_release");
`endif

        // Reset during RAISING cycle 2, then normal service
        entry_base = n_entry;
        step(1, 1, 1, 0, O_MOVE, "mid_raise_c1");
        step(1, 0, 1, 0, O_MOVE, "mid_raise_c2");
        step(0, 0, 1, 0, O_IDLE, "mid_raise_reset");
        step(1, 0, 1, 0, O_IDLE, "mid_raise_release");
        raise_to_open("post_reset_raise");
        car_and_lower("post_reset_lower");
        check_entries(entry_base + 1, "post_reset_entry_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
